// File: rtl/mdu_pkg.sv
// Shared MDOp encodings, FSM state type and constant helpers for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [2:0] MD_MADD  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MAX_WIDTH = 256;

  // Most-negative two's-complement value of width w, right-aligned; slice to the width in use.
  function automatic logic [MD_MAX_WIDTH-1:0] most_neg(input int unsigned w);
    logic [MD_MAX_WIDTH-1:0] one;
    one = {{(MD_MAX_WIDTH-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product/quotient/remainder for the MD unit, including divide-by-zero and
// signed-overflow results.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MD_MAX_WIDTH-1:0] MostNegFull = most_neg(WIDTH);
  localparam logic [WIDTH-1:0]        MOST_NEG    = MostNegFull[WIDTH-1:0];

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               signed_op, a_neg, b_neg, b_zero, overflow;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor, quo, rem, quo_s, rem_s;

  // Low 2*WIDTH bits of an unsigned multiply of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign signed_op = (op == MD_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign b_zero    = (b == '0);
  assign overflow  = signed_op & (a == MOST_NEG) & (b == '1);

  assign mag_a   = a_neg ? -a : a;
  assign mag_b   = b_neg ? -b : b;
  // Divisor forced non-zero so the divider never produces X; the zero case is overridden below.
  assign divisor = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign quo     = mag_a / divisor;
  assign rem     = mag_a % divisor;
  assign quo_s   = (a_neg ^ b_neg) ? -quo : quo;
  assign rem_s   = a_neg ? -rem : rem;

  always_comb begin
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT, MD_MADD: {hi, lo} = prod_s;
      MD_MULTU:         {hi, lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b_zero) begin
          lo = '1;
          hi = a;
        end else if (overflow) begin
          lo = MOST_NEG;
          hi = '0;
        end else begin
          lo = quo_s;
          hi = rem_s;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional madd accumulate is enabled by defining MDU_MADD_EN.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Stall_MD
);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   shadow_hi, shadow_lo;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] result;
  logic               is_multi, is_mul;

  mdu_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .op(MDOp),
    .a (SrcA),
    .b (SrcB),
    .hi(res_hi),
    .lo(res_lo)
  );

  always_comb begin
    is_multi = 1'b0;
    is_mul   = 1'b0;
    case (MDOp)
      MD_MULT, MD_MULTU: begin
        is_multi = 1'b1;
        is_mul   = 1'b1;
      end
      MD_DIV, MD_DIVU: is_multi = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD: begin
        is_multi = 1'b1;
        is_mul   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef MDU_MADD_EN
  // Accumulator addend is the architectural HI:LO at issue; wraps modulo 2^(2*WIDTH).
  assign result = {res_hi, res_lo} + ((MDOp == MD_MADD) ? {HI, LO} : {(2*WIDTH){1'b0}});
`else
  assign result = {res_hi, res_lo};
`endif

  assign Stall_MD = Busy | (Start & is_multi);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      Busy      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (is_multi) begin
              {shadow_hi, shadow_lo} <= result;
              cnt   <= is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
              state <= ST_RUN;
              Busy  <= 1'b1;
            end else if (MDOp == MD_MTHI) begin
              HI <= SrcA;
            end else if (MDOp == MD_MTLO) begin
              LO <= SrcA;
            end
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            HI    <= shadow_hi;
            LO    <= shadow_lo;
            cnt   <= '0;
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, placed in the E stage of the five-stage pipeline beside the ALU.
- Executes mult/multu/div/divu over a configurable latency and supports single-cycle mthi/mtlo.
- Exposes Busy so the hazard unit stalls later mfhi/mflo and MD instructions in D.
- Fixed-latency successor to the single-cycle ALU path; operand width and latencies are generic.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=8, even)
MUL_CYCLES, 5, Busy cycles for mult/multu/madd (>=1)
DIV_CYCLES, 10, Busy cycles for div/divu (>=1)
CNT_W, 8, latency counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
Start  in  1  E-stage MD instruction valid this cycle (already qualified by the pipeline)
MDOp  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 madd
SrcA  in  WIDTH  forwarded rs value
SrcB  in  WIDTH  forwarded rt value
Busy  out  1  multi-cycle operation in progress
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register
Stall_MD  out  1  Busy | (Start & MDOp in {001,010,011,100,111}); to the hazard unit

Behaviour:
- Reset low: state IDLE, counter 0, Busy 0, HI 0, LO 0, shadow registers 0. Aborts any operation in flight immediately. No completion writes after release.
- States: IDLE, RUN.
- IDLE + Start + multi-cycle op in cycle t:
  - Latch operands, op, and the computed {hi,lo} into shadow registers.
  - Load counter with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - Busy is high in cycles t+1 .. t+N.
- RUN:
  - Counter decrements each cycle.
  - At the edge where counter==1, commit shadow to HI/LO and go to IDLE.
  - Busy falls and new HI/LO are visible in the same cycle t+N+1.
- Start while RUN: ignored. The hazard unit guarantees this does not occur; the bench asserts on it.
- mthi/mtlo with Start in IDLE: HI (or LO) <= SrcA at the end of cycle t. Busy stays 0. Latency 1.
- MDOp 000 with Start, or Start low: no effect.
- Arithmetic:
  - mult: signed 2*WIDTH product, HI = upper half, LO = lower half.
  - multu: unsigned product, same split.
  - div: signed; quotient truncates toward zero; remainder takes the sign of the dividend; LO = quotient, HI = remainder.
  - divu: unsigned; LO = quotient, HI = remainder.
  - Divide by zero (SrcB==0): LO = all ones, HI = SrcA. Latency is unchanged.
  - Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- Stall_MD is combinational. It covers the issue cycle so that an mfhi/mflo in D stalls from cycle t.
- Operands are sampled only at Start; later changes to SrcA/SrcB do not affect the result.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MDOp 111 (madd) adds the signed 2*WIDTH product of SrcA*SrcB to {HI,LO}. Uses MUL_CYCLES. The addend {HI,LO} is sampled at Start; wrap-around is modulo 2^(2*WIDTH).
- Undefined: MDOp 111 is treated as 000 (no-op, no Busy), and the accumulate adder is not synthesised.

Decomposition:
- Shared package mdu_pkg holds:
  - MDOp localparams: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD.
  - State encodings ST_IDLE and ST_RUN.
  - Helper constant for the most-negative WIDTH value.
- One natural sub-module, mdu_arith: the combinational product/quotient/remainder calculation, including the div-by-zero and overflow rules. mdu_unit keeps the FSM, counter, shadow registers and HI/LO.

Test Plan:
- mult SrcA=0xFFFFFFFE (-2), SrcB=3 at t -> Busy high t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 Busy cycles.
- div SrcA=-7 (0xFFFFFFF9), SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 Busy cycles. divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 in consecutive cycles -> HI and LO updated one cycle each, Busy never asserts, Stall_MD stays 0.
- Reset low during cycle 3 of a div -> Busy=0 and HI=LO=0 immediately; after release, no late commit occurs over 15 cycles.
- With MDU_MADD_EN: HI:LO=0x00000000_FFFFFFFF, madd 1*1 -> HI=0x00000001, LO=0x00000000. Without it, MDOp 111 leaves HI/LO unchanged and Busy=0.
